envelope_config_writer: RTL and testbench

Host-side producer for the envelope attenuator's configuration write port. It accepts parameter-write commands over a valid/ready handshake and buffers them in a small FIFO. Each command is range-checked and saturated, then issued as a single-cycle one-hot write strobe with the operator address and data. A broadcast command sweeps one value across every voice operator, one write per clock. The block sits between the host register/SPI decoder and the envelope stage.

---
 rtl/envelope_config_writer.sv | 174 +++++++++++++++++
 tb/tb_envelope_config_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_config_writer.sv
// Buffers host parameter-write commands and issues one-hot configuration write strobes to
// the envelope stage. Each command writes one operator or is swept across every operator.
module envelope_config_writer #(
    parameter int NUM_VOICE_OPERATORS = 256,
    parameter int OP_ID_WIDTH         = 8,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_CmdValid,
    output logic                   o_CmdReady,
    input  logic [2:0]             i_CmdParam,
    input  logic [OP_ID_WIDTH-1:0] i_CmdAddr,
    input  logic                   i_CmdBroadcast,
    input  logic [15:0]            i_CmdData,
    input  logic                   i_ClearFlags,
    output logic [4:0]             o_EnvelopeConfigWriteEnable,
    output logic [OP_ID_WIDTH-1:0] o_ConfigWriteAddr,
    output logic [15:0]            o_ConfigWriteData,
    output logic                   o_Busy,
    output logic                   o_InvalidParam,
    output logic                   o_Saturated
);

    // state   | meaning
    // S_IDLE  | nothing in flight; pops the FIFO head when one is present
    // S_WRITE | single write of cur_* goes out on the next edge
    // S_SWEEP | broadcast write of cur_data to sweep_addr goes out on the next edge
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SWEEP} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [OP_ID_WIDTH-1:0] LAST_OP    = OP_ID_WIDTH'(NUM_VOICE_OPERATORS - 1);
    localparam logic [15:0]            LEVEL_MAX  = 16'h3fff;
    localparam logic [15:0]            RATE_MAX   = 16'h0fff;

    state_t state, state_next;

    logic [2:0]             fifo_param [FIFO_DEPTH];
    logic [OP_ID_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic                   fifo_bcast [FIFO_DEPTH];
    logic [15:0]            fifo_data  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;

    logic [2:0]             cur_param;
    logic [OP_ID_WIDTH-1:0] cur_addr;
    logic [15:0]            cur_data;
    logic [OP_ID_WIDTH-1:0] sweep_addr, sweep_addr_next;

    logic                   accept, param_ok, push, pop, over_limit;
    logic [15:0]            sat_data;
    logic [4:0]             strobe_d;
    logic [OP_ID_WIDTH-1:0] addr_d;
    logic [15:0]            data_d;

    assign o_CmdReady = (count != FULL_COUNT);
    assign accept     = i_CmdValid && o_CmdReady;
    assign param_ok   = (i_CmdParam <= 3'd4);
    assign push       = accept && param_ok;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        over_limit = 1'b0;
        sat_data   = i_CmdData;
        if (i_CmdParam <= 3'd1) begin
            if (i_CmdData > LEVEL_MAX) begin
                over_limit = 1'b1;
                sat_data   = LEVEL_MAX;
            end
        end else if (param_ok) begin
            if (i_CmdData > RATE_MAX) begin
                over_limit = 1'b1;
                sat_data   = RATE_MAX;
            end
        end
    end

    // Sequencing: a pop is allowed from every state that is about to finish, so writes
    // stream back-to-back without a bubble.
    always_comb begin
        state_next      = state;
        sweep_addr_next = sweep_addr;
        pop             = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) pop = 1'b1;
            end
            S_WRITE: begin
                if (count != '0) pop = 1'b1;
                else             state_next = S_IDLE;
            end
            S_SWEEP: begin
                if (sweep_addr == LAST_OP) begin
                    if (count != '0) pop = 1'b1;
                    else             state_next = S_IDLE;
                end else begin
                    sweep_addr_next = sweep_addr + OP_ID_WIDTH'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (pop) begin
            state_next      = fifo_bcast[rd_ptr] ? S_SWEEP : S_WRITE;
            sweep_addr_next = '0;
        end
    end

    always_comb begin
        strobe_d = 5'b0;
        addr_d   = '0;
        data_d   = '0;
        if (state == S_WRITE) begin
            strobe_d = 5'b00001 << cur_param;
            addr_d   = cur_addr;
            data_d   = cur_data;
        end else if (state == S_SWEEP) begin
            strobe_d = 5'b00001 << cur_param;
            addr_d   = sweep_addr;
            data_d   = cur_data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_param[wr_ptr] <= i_CmdParam;
            fifo_addr[wr_ptr]  <= i_CmdAddr;
            fifo_bcast[wr_ptr] <= i_CmdBroadcast;
            fifo_data[wr_ptr]  <= sat_data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state                       <= S_IDLE;
            sweep_addr                  <= '0;
            count                       <= '0;
            wr_ptr                      <= '0;
            rd_ptr                      <= '0;
            cur_param                   <= '0;
            cur_addr                    <= '0;
            cur_data                    <= '0;
            o_EnvelopeConfigWriteEnable <= 5'b0;
            o_ConfigWriteAddr           <= '0;
            o_ConfigWriteData           <= '0;
            o_Busy                      <= 1'b0;
            o_InvalidParam              <= 1'b0;
            o_Saturated                 <= 1'b0;
        end else begin
            state      <= state_next;
            sweep_addr <= sweep_addr_next;
            count      <= count_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                cur_param <= fifo_param[rd_ptr];
                cur_addr  <= fifo_addr[rd_ptr];
                cur_data  <= fifo_data[rd_ptr];
            end
            o_EnvelopeConfigWriteEnable <= strobe_d;
            o_ConfigWriteAddr           <= addr_d;
            o_ConfigWriteData           <= data_d;
            o_Busy <= (count_next != '0) || (state_next != S_IDLE) || (strobe_d != 5'b0);
            // A new flag event outranks a simultaneous clear.
            if (accept && !param_ok)           o_InvalidParam <= 1'b1;
            else if (i_ClearFlags)             o_InvalidParam <= 1'b0;
            if (accept && param_ok && over_limit) o_Saturated <= 1'b1;
            else if (i_ClearFlags)             o_Saturated    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_envelope_config_writer.sv
// Randomised and directed bench for envelope_config_writer: a reference model expands each
// accepted command into its expected writes, and a monitor matches them against the strobes.
module tb_envelope_config_writer;

    localparam int NUM = 256;
    localparam int OPW = 8;
    localparam int DEP = 4;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_param;
    logic [OPW-1:0] cmd_addr;
    logic           cmd_bcast;
    logic [15:0]    cmd_data;
    logic           clear_flags;
    logic [4:0]     wr_en;
    logic [OPW-1:0] wr_addr;
    logic [15:0]    wr_data;
    logic           busy;
    logic           invalid_flag;
    logic           sat_flag;

    envelope_config_writer #(
        .NUM_VOICE_OPERATORS(NUM),
        .OP_ID_WIDTH(OPW),
        .FIFO_DEPTH(DEP)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_CmdValid(cmd_valid),
        .o_CmdReady(cmd_ready),
        .i_CmdParam(cmd_param),
        .i_CmdAddr(cmd_addr),
        .i_CmdBroadcast(cmd_bcast),
        .i_CmdData(cmd_data),
        .i_ClearFlags(clear_flags),
        .o_EnvelopeConfigWriteEnable(wr_en),
        .o_ConfigWriteAddr(wr_addr),
        .o_ConfigWriteData(wr_data),
        .o_Busy(busy),
        .o_InvalidParam(invalid_flag),
        .o_Saturated(sat_flag)
    );

    typedef struct packed {
        logic [4:0]     en;
        logic [OPW-1:0] addr;
        logic [15:0]    data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic m_invalid = 1'b0;
    logic m_sat = 1'b0;
    int   run_len = 0;
    int   last_run = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: what the attenuator port must see for one accepted command.
    function automatic void model_accept(input logic [2:0] p, input logic [OPW-1:0] a,
                                         input logic b, input logic [15:0] d);
        logic [15:0] lim;
        wr_t         w;
        if (p > 3'd4) begin
            m_invalid = 1'b1;
            return;
        end
        lim = (p < 3'd2) ? 16'h3fff : 16'h0fff;
        w.en   = 5'b00001 << p;
        w.data = d;
        if (d > lim) begin
            w.data = lim;
            m_sat  = 1'b1;
        end
        if (b) begin
            for (int i = 0; i < NUM; i++) begin
                w.addr = OPW'(i);
                exp_q.push_back(w);
            end
        end else begin
            w.addr = a;
            exp_q.push_back(w);
        end
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [2:0] p, input logic [OPW-1:0] a, input logic b,
                        input logic [15:0] d);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_param = p;
        cmd_addr  = a;
        cmd_bcast = b;
        cmd_data  = d;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            model_accept(p, a, b, d);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        m_invalid = 1'b0;
        m_sat     = 1'b0;
    endtask

    // Monitor: every strobe must be the next expected write, in order.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (wr_en != 5'b0) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual en=%b addr=%0d data=%0h required none",
                             wr_en, wr_addr, wr_data);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_en", 32'(wr_en), 32'(w.en));
                    check("wr_addr", 32'(wr_addr), 32'(w.addr));
                    check("wr_data", 32'(wr_data), 32'(w.data));
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [2:0]  rp;
        logic        rb;
        logic [15:0] rd;
        cmd_valid   = 1'b0;
        cmd_param   = '0;
        cmd_addr    = '0;
        cmd_bcast   = 1'b0;
        cmd_data    = '0;
        clear_flags = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_en", 32'(wr_en), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {30'd0, invalid_flag, sat_flag}, 32'd0);

        // Single write and its latency.
        send(3'd2, 8'd7, 1'b0, 16'h0123);
        check("single_busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_e1_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        check("single_e2_en", 32'(wr_en), 32'b00100);
        check("single_e2_addr", 32'(wr_addr), 32'd7);
        check("single_e2_data", 32'(wr_data), 32'h0123);
        @(negedge clk);
        check("single_e3_en", 32'(wr_en), 32'd0);
        check("single_e3_busy", 32'(busy), 32'd0);

        // Saturation and exact limits.
        send(3'd0, 8'd3, 1'b0, 16'hffff);
        send(3'd4, 8'd9, 1'b0, 16'h1000);
        send(3'd1, 8'd2, 1'b0, 16'h3fff);
        send(3'd3, 8'd4, 1'b0, 16'h0fff);
        wait_idle(50);
        check("sat_flag", 32'(sat_flag), 32'(m_sat));
        check("sat_invalid", 32'(invalid_flag), 32'(m_invalid));
        pulse_clear();
        check("sat_cleared", 32'(sat_flag), 32'd0);
        clear_flags = 1'b1;
        send(3'd0, 8'd1, 1'b0, 16'h4000);
        clear_flags = 1'b0;
        check("sat_set_wins", 32'(sat_flag), 32'(m_sat));
        wait_idle(50);
        pulse_clear();

        // Invalid parameter is dropped.
        send(3'd6, 8'd1, 1'b0, 16'h1234);
        check("inv_ready", 32'(cmd_ready), 32'd1);
        check("inv_flag", 32'(invalid_flag), 32'd1);
        repeat (4) @(negedge clk);
        check("inv_busy", 32'(busy), 32'd0);
        pulse_clear();
        check("inv_cleared", 32'(invalid_flag), 32'd0);

        // Broadcast followed by a single write with no gap.
        send(3'd1, 8'd99, 1'b1, 16'h2000);
        send(3'd3, 8'd5, 1'b0, 16'h0042);
        wait_idle(600);
        check("bcast_run_len", 32'(last_run), 32'(NUM + 1));

        // Back-pressure during a sweep.
        send(3'd0, 8'd0, 1'b1, 16'h0100);
        for (int i = 0; i < 6; i++) begin
            send(3'((i + 2) % 5), OPW'(10 + i), 1'b0, 16'(i * 16'h0111));
            if (i == DEP - 1) check("bp_ready_low", 32'(cmd_ready), 32'd0);
        end
        wait_idle(600);
        check("bp_ready_back", 32'(cmd_ready), 32'd1);

        // Reset in the middle of a sweep with commands still queued.
        send(3'd1, 8'd0, 1'b1, 16'h0777);
        send(3'd2, 8'd3, 1'b0, 16'h0055);
        send(3'd0, 8'd4, 1'b0, 16'hffff);
        n = 0;
        while (!(wr_en != 5'b0 && wr_addr == 8'd100) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_addr", 32'(wr_addr), 32'd100);
        rst = 1'b1;
        exp_q.delete();
        m_invalid = 1'b0;
        m_sat     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_en", 32'(wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_flags", {30'd0, invalid_flag, sat_flag}, 32'd0);
        @(negedge clk);
        check("post_rst_en", 32'(wr_en), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            rp = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       rd = 16'($urandom);
                1: begin
                    case ($urandom_range(0, 3))
                        0:       rd = 16'h3fff;
                        1:       rd = 16'h4000;
                        2:       rd = 16'h0fff;
                        default: rd = 16'h1000;
                    endcase
                end
                2:       rd = 16'($urandom_range(0, 255));
                default: rd = 16'hffff;
            endcase
            send(rp, OPW'($urandom), rb, rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(6000);
        check("rand_invalid", 32'(invalid_flag), 32'(m_invalid));
        check("rand_sat", 32'(sat_flag), 32'(m_sat));
        check("rand_ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
